// File: rtl/mem_access.sv
// mem_access: memory-stage dbus controller; builds the aligned request, runs addr_ok/data_ok, hands raw word to formatter.
// Latency: aligned op with same-cycle addr_ok/data_ok -> out_valid 2 cycles after accept; non-mem/misaligned -> 1 cycle.
// Backpressure: in_ready only in IDLE (upstream stalls while an op is in flight); result held in DONE until out_ready.
// Ports: in_* = op from EX/MEM (valid/ready), dreq_*/dresp_* = data bus, out_* = result to load formatter.
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [63:0] in_addr,
  input  logic [1:0]  in_msize,
  input  logic        in_unsigned,
  input  logic [63:0] in_wdata,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic [2:0]  out_addr_lo,
  output logic [1:0]  out_msize,
  output logic        out_unsigned,
  output logic        out_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;
  localparam logic [1:0] MSIZE8 = 2'd3;

  state_t      state_q;
  logic [63:0] addr_q;
  logic [1:0]  msize_q;
  logic        unsigned_q;
  logic        load_q;
  logic        misalign_q;
  logic [7:0]  strobe_q;
  logic [63:0] sdata_q;
  logic [63:0] rdata_q;

  // Accept-time decodes of the incoming op; they become the held request.
  logic [2:0]  lane;
  logic        is_mem;
  logic        misalign_d;
  logic [7:0]  strobe_d;
  logic [63:0] sdata_d;

  always_comb begin
    lane       = in_addr[2:0];
    is_mem     = in_load | in_store;
    misalign_d = 1'b0;
    strobe_d   = 8'h00;
    case (in_msize)
      MSIZE1: begin
        misalign_d = 1'b0;
        strobe_d   = 8'h01 << lane;
      end
      MSIZE2: begin
        misalign_d = lane[0];
        strobe_d   = 8'h03 << lane;
      end
      MSIZE4: begin
        misalign_d = (lane[1:0] != 2'b00);
        strobe_d   = 8'h0F << lane;
      end
      MSIZE8: begin
        misalign_d = (lane != 3'b000);
        strobe_d   = 8'hFF;
      end
      default: begin
        misalign_d = 1'b0;
        strobe_d   = 8'h00;
      end
    endcase
    // Loads never write a byte lane.
    if (!in_store) begin
      strobe_d = 8'h00;
    end
    // Bytes pushed past bit 63 fall off; the strobe never covers them.
    sdata_d = in_wdata << {lane, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 64'd0;
      msize_q    <= 2'd0;
      unsigned_q <= 1'b0;
      load_q     <= 1'b0;
      misalign_q <= 1'b0;
      strobe_q   <= 8'h00;
      sdata_q    <= 64'd0;
      rdata_q    <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            addr_q     <= in_addr;
            msize_q    <= in_msize;
            unsigned_q <= in_unsigned;
            load_q     <= in_load;
            strobe_q   <= strobe_d;
            sdata_q    <= sdata_d;
            rdata_q    <= 64'd0;
            // Misalignment is only meaningful for real memory ops.
            misalign_q <= is_mem & misalign_d;
            if (!is_mem || misalign_d) begin
              state_q <= DONE;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          // data_ok before the address is accepted is not a valid response.
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              rdata_q <= load_q ? dresp_data : 64'd0;
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dresp_data_ok) begin
            rdata_q <= load_q ? dresp_data : 64'd0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign dreq_valid   = (state_q == REQ);
  assign dreq_addr    = {addr_q[63:3], 3'b000};
  assign dreq_size    = msize_q;
  assign dreq_strobe  = strobe_q;
  assign dreq_data    = sdata_q;
  assign out_valid    = (state_q == DONE);
  assign out_rdata    = rdata_q;
  assign out_addr_lo  = addr_q[2:0];
  assign out_msize    = msize_q;
  assign out_unsigned = unsigned_q;
  assign out_misalign = misalign_q;

endmodule
